serial_subtractor: RTL

//  Bit-serial two's-complement subtractor: computes DIFF = A - B, one bit per clock, LSB first.
//  It is the inverse operation of the board's parallel adders.
//  It sits between switch-sampled operands and the LED outputs.
//  It trades the ripple-carry chain for a single borrow flop plus a start/done handshake.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_if.sv | 14 +
 rtl/serial_subtractor_full_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and
// a constant-evaluable ceil(log2) used to size the bit counter.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ceil(log2(v)); 0 for v<=1, so callers clamp to a minimum of 1 bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake plus operand/result bus of the serial subtractor.
// master: the requester driving operands; slave: the subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bout set on underflow.
// Mirror of the board's full_adder cell.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit
// per clock through a single full_subtractor and a borrow flop.
// Optional build macro SERIAL_SUBTRACTOR_SATURATE_EN: clamp diff to 0 on
// underflow (borrow_out still reports the underflow).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             d, bout;
  logic [WIDTH-1:0] res_next, diff_load;
  logic             accept;

  full_subtractor u_fs (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (borrow),
    .D    (d),
    .Bout (bout)
  );

  // new bit enters at the MSB so the LSB-first stream lands in place
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_next = d;
    end else begin : g_wn
      assign res_next = {d, res_sr[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
  assign diff_load = bout ? '0 : res_next;
`else
  assign diff_load = res_next;
`endif

  // start only counts when idle or in the single DONE cycle (back-to-back)
  assign accept = bus.start && (state == ST_IDLE || state == ST_DONE);

  // FSM plus serial datapath; results load only on the SUB->DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      borrow   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= ST_SUB;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_SUB: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= bout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff_q   <= diff_load;
            borrow_q <= bout;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == ST_SUB);
  assign bus.done       = (state == ST_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule
